bsg_mesh_traffic_node: RTL and testbench
========================================

Name: bsg_mesh_traffic_node

Overview:
- Synthesizable per-tile traffic generator and checker attached to the P port of a bsg_mesh_router.
- Replaces hand-written bench stimulus. Supports three destination patterns: all-to-all, transpose and LFSR-random.
- Packets carry per-destination sequence numbers. The checker can therefore verify routing and per-source in-order delivery on meshes of any power-of-2 size.
- Exposes counters and a sticky error code for bench or on-chip status.

Parameters:
- x_cord_width_p, 2, x coordinate width; mesh x dimension = 2**x_cord_width_p.
- y_cord_width_p, 2, y coordinate width; mesh y dimension = 2**y_cord_width_p.
- seq_width_p, 8, sequence field width.
- packets_p, 4, number of rounds; total sent = packets_p * 2**(x+y).
- lfsr_seed_p, 'h5A, random-mode seed; XORed with tile id.
- Derived: id_w = x_cord_width_p + y_cord_width_p; width_lp = 2*id_w + seq_width_p.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- my_x_i  in  x_cord_width_p  tile x coordinate.
- my_y_i  in  y_cord_width_p  tile y coordinate.
- mode_i  in  2  pattern select: 0 all-to-all, 1 transpose, 2 random, 3 reserved (treated as 0). Sampled on start.
- start_i  in  1  single-cycle pulse; starts generation.
- data_o  out  width_lp  packet to router P input.
- v_o  out  1  packet valid.
- ready_i  in  1  router/FIFO ready; transfer when v_o & ready_i.
- data_i  in  width_lp  packet from router P output.
- v_i  in  1  incoming packet valid.
- yumi_o  out  1  consume incoming packet.
- sent_count_o  out  32  packets sent.
- recv_count_o  out  32  packets accepted.
- gen_done_o  out  1  all packets sent.
- error_o  out  1  sticky error flag.
- error_code_o  out  2  first error: 1 misroute, 2 sequence mismatch.

Behaviour:
- Packet layout, LSB first: dest_x, dest_y, src_x, src_y, seq. Coordinates occupy the low bits, as the router requires.
- Reset (reset_n_i low, asynchronous):
  - Outputs: v_o=0, yumi_o=0, gen_done_o=0, error_o=0, error_code_o=0, all counters 0.
  - State: FSM returns to IDLE; LFSR loads lfsr_seed_p ^ id; all per-destination and per-source sequence arrays clear to 0.
- Generator FSM states: IDLE, SEND, DONE.
  - IDLE -> SEND on start_i. Latches mode and clears round and index.
  - SEND: v_o=1 continuously. data_o is held stable until transfer. On transfer:
    - increment sent_count;
    - increment dest_seq[dest] (wraps mod 2**seq_width_p);
    - advance index; after 2**id_w transfers, advance round.
  - SEND -> DONE after the transfer that makes sent_count = packets_p * 2**id_w. DONE asserts gen_done_o.
  - start_i is ignored outside IDLE. Re-arming a node requires reset.
- Destination selection:
  - Mode 0: dest = id ^ index.
  - Mode 1: dest = (x=my_y, y=my_x). Requires x_cord_width_p == y_cord_width_p; otherwise mode 1 behaves as mode 0.
  - Mode 2: dest = low id_w bits of a maximal-length 16-bit Fibonacci LFSR. The LFSR steps once per transfer only.
  - Self-destination is legal in all modes.
- seq field = dest_seq[dest] at the time of transfer.
- Checker:
  - yumi_o = v_i (always accepts), registered-free. Zero cycles from v_i to yumi_o; one cycle to counter/error update.
  - On accept: recv_count++.
  - If dest != (my_x, my_y): misroute error.
  - Else if seq != exp_seq[src]: sequence error, and exp_seq[src] resyncs to seq+1.
  - Else exp_seq[src]++.
- Error capture: error_o and error_code_o capture the first error only; later errors do not overwrite. Misroute takes priority over sequence within one packet.
- Counters saturate at 2**32-1.
- Generator and checker run concurrently and independently. Simultaneous send and receive in the same cycle are both processed.
- Reset mid-SEND drops v_o asynchronously; an in-flight packet is the bench's concern.

Test Plan:
- 1x1 mesh (widths 0 treated as 1-bit ids tied 0), mode 0, packets_p=4 -> 4 loopback packets; recv seq 0,1,2,3; recv_count=4; error_o=0.
- 4x4 mesh of nodes, mode 0, packets_p=4 -> every node sent_count=64, recv_count=64, gen_done_o=1, error_o=0 within 5000 cycles.
- 4x4 mesh, mode 1 -> tile (1,2) receives all 64 packets from (2,1) with seq 0..63; diagonal tiles receive only from themselves; no errors.
- Single node, ready_i held low 10 cycles mid-SEND -> data_o stable throughout, sent_count unchanged; resumes on ready_i.
- Inject packet with dest=(3,3) into node (0,0) -> error_o=1, error_code_o=1 next cycle. A following in-order packet leaves code at 1.
- Inject src=(1,0) with seq 0 then 2 -> error_code_o=2. Next seq 3 is accepted without a new error; recv_count=3.

Source files
------------

// File: rtl/bsg_mesh_traffic_node.sv
// bsg_mesh_traffic_node
//   Per-tile traffic generator and checker for the P port of a mesh router.
//   The generator sends packets_p rounds of 2**(x+y) packets using one of
//   three destination patterns (all-to-all, transpose, LFSR-random). Each
//   packet carries a per-destination sequence number. The checker accepts
//   every incoming packet, flags misroutes and per-source sequence breaks,
//   and keeps saturating counters plus a sticky first-error code.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   my_x_i, my_y_i          coordinates of this tile
//   mode_i, start_i         pattern select (sampled on start), start pulse
//   data_o, v_o, ready_i    outgoing packet, valid/ready handshake
//   data_i, v_i, yumi_o     incoming packet, valid, consume (= v_i)
//   sent_count_o            packets sent (saturating)
//   recv_count_o            packets accepted (saturating)
//   gen_done_o              all packets sent
//   error_o, error_code_o   sticky error, first error (1 misroute, 2 sequence)
//
// Packet layout, LSB first: dest_x, dest_y, src_x, src_y, seq.

module bsg_mesh_traffic_node #(
   parameter int x_cord_width_p = 2,
   parameter int y_cord_width_p = 2,
   parameter int seq_width_p    = 8,
   parameter int packets_p      = 4,
   parameter int lfsr_seed_p    = 'h5A,
   localparam int id_w_lp       = x_cord_width_p + y_cord_width_p,
   localparam int width_lp      = 2*id_w_lp + seq_width_p
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [x_cord_width_p-1:0] my_x_i,
   input  logic [y_cord_width_p-1:0] my_y_i,
   input  logic [1:0]                mode_i,
   input  logic                      start_i,
   output logic [width_lp-1:0]       data_o,
   output logic                      v_o,
   input  logic                      ready_i,
   input  logic [width_lp-1:0]       data_i,
   input  logic                      v_i,
   output logic                      yumi_o,
   output logic [31:0]               sent_count_o,
   output logic [31:0]               recv_count_o,
   output logic                      gen_done_o,
   output logic                      error_o,
   output logic [1:0]                error_code_o
);

   localparam int nodes_lp   = 1 << id_w_lp;
   localparam int round_w_lp = (packets_p > 1) ? $clog2(packets_p) : 1;
   localparam bit transpose_ok_lp = (x_cord_width_p == y_cord_width_p);
   localparam logic [15:0] seed_lp = 16'(lfsr_seed_p);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // x^16 + x^14 + x^13 + x^11 + 1, maximal length
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   state_e                 state_q, state_d;
   logic [1:0]             mode_q, mode_d;
   logic [id_w_lp-1:0]     index_q, index_d;
   logic [round_w_lp-1:0]  round_q, round_d;
   logic [15:0]            lfsr_q, lfsr_d;
   logic [31:0]            sent_q, sent_d, recv_q, recv_d;
   logic                   err_q, err_d;
   logic [1:0]             code_q, code_d;
   logic [seq_width_p-1:0] dest_seq_q [nodes_lp];
   logic [seq_width_p-1:0] dest_seq_d [nodes_lp];
   logic [seq_width_p-1:0] exp_seq_q  [nodes_lp];
   logic [seq_width_p-1:0] exp_seq_d  [nodes_lp];

   logic [id_w_lp-1:0]     my_id, dest, seed_id;
   logic [id_w_lp-1:0]     in_dest, in_src;
   logic [seq_width_p-1:0] in_seq;
   logic [15:0]            seeded;
   logic                   last_xfer;

   assign my_id   = {my_y_i, my_x_i};
   // transposed id: dest_x = my_y, dest_y = my_x (only meaningful for square ids)
   assign seed_id = {my_x_i, my_y_i};

   // The seed is applied at start so the reset value stays a constant; the
   // LFSR is only observed in SEND so this is indistinguishable externally.
   // An all-zero seed would lock the LFSR, so it is bumped to 1.
   assign seeded = ((seed_lp ^ 16'(my_id)) == 16'd0) ? 16'd1 : (seed_lp ^ 16'(my_id));

   always_comb begin
      dest = my_id ^ index_q;
      if (mode_q == 2'd1 && transpose_ok_lp) dest = seed_id;
      else if (mode_q == 2'd2)               dest = lfsr_q[id_w_lp-1:0];
   end

   assign data_o    = {dest_seq_q[dest], my_id, dest};
   assign last_xfer = (index_q == id_w_lp'(nodes_lp-1)) &&
                      (round_q == round_w_lp'(packets_p-1));

   assign in_dest = data_i[id_w_lp-1:0];
   assign in_src  = data_i[2*id_w_lp-1:id_w_lp];
   assign in_seq  = data_i[width_lp-1:2*id_w_lp];

   assign yumi_o       = v_i;
   assign sent_count_o = sent_q;
   assign recv_count_o = recv_q;
   assign error_o      = err_q;
   assign error_code_o = code_q;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      index_d    = index_q;
      round_d    = round_q;
      lfsr_d     = lfsr_q;
      sent_d     = sent_q;
      recv_d     = recv_q;
      err_d      = err_q;
      code_d     = code_q;
      dest_seq_d = dest_seq_q;
      exp_seq_d  = exp_seq_q;
      v_o        = 1'b0;
      gen_done_o = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SEND;
               mode_d  = mode_i;
               index_d = '0;
               round_d = '0;
               lfsr_d  = seeded;
            end
         end
         SEND: begin
            v_o = 1'b1;
            if (ready_i) begin
               sent_d           = sat_inc(sent_q);
               dest_seq_d[dest] = dest_seq_q[dest] + 1'b1;
               index_d          = index_q + 1'b1;
               if (index_q == id_w_lp'(nodes_lp-1)) round_d = round_q + 1'b1;
               lfsr_d           = lfsr_next(lfsr_q);
               if (last_xfer) state_d = DONE;
            end
         end
         DONE:    gen_done_o = 1'b1;
         default: state_d = IDLE;
      endcase

      // Checker: misroute has priority; a sequence break resyncs to seq+1.
      if (v_i) begin
         recv_d = sat_inc(recv_q);
         if (in_dest != my_id) begin
            if (!err_q) begin
               err_d  = 1'b1;
               code_d = 2'd1;
            end
         end else if (in_seq != exp_seq_q[in_src]) begin
            if (!err_q) begin
               err_d  = 1'b1;
               code_d = 2'd2;
            end
            exp_seq_d[in_src] = in_seq + 1'b1;
         end else begin
            exp_seq_d[in_src] = exp_seq_q[in_src] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         mode_q     <= 2'd0;
         index_q    <= '0;
         round_q    <= '0;
         lfsr_q     <= seed_lp;
         sent_q     <= 32'd0;
         recv_q     <= 32'd0;
         err_q      <= 1'b0;
         code_q     <= 2'd0;
         dest_seq_q <= '{default: '0};
         exp_seq_q  <= '{default: '0};
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         index_q    <= index_d;
         round_q    <= round_d;
         lfsr_q     <= lfsr_d;
         sent_q     <= sent_d;
         recv_q     <= recv_d;
         err_q      <= err_d;
         code_q     <= code_d;
         dest_seq_q <= dest_seq_d;
         exp_seq_q  <= exp_seq_d;
      end
   end

endmodule

// File: tb/tb_bsg_mesh_traffic_node.sv
// Directed testbench for bsg_mesh_traffic_node (2x2-bit coordinates,
// 8-bit sequence, 4 rounds -> 64 packets per node).
// Packet value = seq<<8 | src_y<<6 | src_x<<4 | dest_y<<2 | dest_x.

module tb_bsg_mesh_traffic_node;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  my_x, my_y, mode;
   logic        start, ready;
   logic [15:0] data_o, data_i, d_inj;
   logic        v_o, v_i, v_inj, yumi;
   logic        loop_en;
   logic [31:0] sent, recv;
   logic        gen_done, err;
   logic [1:0]  code;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign v_i    = loop_en ? (v_o & ready) : v_inj;
   assign data_i = loop_en ? data_o : d_inj;

   bsg_mesh_traffic_node #(
      .x_cord_width_p(2), .y_cord_width_p(2), .seq_width_p(8),
      .packets_p(4), .lfsr_seed_p('h5A)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n), .my_x_i(my_x), .my_y_i(my_y),
      .mode_i(mode), .start_i(start), .data_o(data_o), .v_o(v_o),
      .ready_i(ready), .data_i(data_i), .v_i(v_i), .yumi_o(yumi),
      .sent_count_o(sent), .recv_count_o(recv), .gen_done_o(gen_done),
      .error_o(err), .error_code_o(code)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset(input logic [1:0] x, input logic [1:0] y, input logic [1:0] m);
      @(negedge clk);
      start = 1'b0; v_inj = 1'b0; d_inj = '0; loop_en = 1'b0; ready = 1'b0;
      my_x = x; my_y = y; mode = m;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Pulses start across one posedge; returns at the first negedge in SEND.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic inject(input logic [15:0] pkt);
      v_inj = 1'b1; d_inj = pkt;
      @(negedge clk);
      v_inj = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; v_inj = 1'b0; d_inj = '0;
      loop_en = 1'b0; my_x = '0; my_y = '0; mode = '0;
      #2;
      chk("rst_v_o", {31'd0, v_o}, 0);
      chk("rst_yumi", {31'd0, yumi}, 0);
      chk("rst_done", {31'd0, gen_done}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_code", {30'd0, code}, 0);
      chk("rst_sent", sent, 0);
      chk("rst_recv", recv, 0);

      // Loopback, transpose on diagonal tile (1,1): all packets to self.
      do_reset(2'd1, 2'd1, 2'd1);
      ready = 1'b1; loop_en = 1'b1;
      pulse_start();
      chk("loop_first_pkt", {16'd0, data_o}, 85);
      for (int i = 0; i < 200 && !gen_done; i++) @(negedge clk);
      chk("loop_done", {31'd0, gen_done}, 1);
      chk("loop_sent", sent, 64);
      chk("loop_recv", recv, 64);
      chk("loop_err", {31'd0, err}, 0);
      chk("loop_v_o", {31'd0, v_o}, 0);

      // Transpose from (1,2) to (2,1) with a ready stall.
      do_reset(2'd1, 2'd2, 2'd1);
      ready = 1'b1;
      pulse_start();
      chk("tr_pkt0", {16'd0, data_o}, 150);
      repeat (3) @(negedge clk);
      chk("tr_sent3", sent, 3);
      chk("tr_pkt3", {16'd0, data_o}, 918);
      ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_data", {16'd0, data_o}, 918);
         chk("stall_v_o", {31'd0, v_o}, 1);
      end
      chk("stall_sent", sent, 3);
      ready = 1'b1;
      @(negedge clk);
      chk("resume_sent", sent, 4);
      chk("resume_pkt4", {16'd0, data_o}, 1174);

      // All-to-all from (1,2): dest = 9 ^ index, seq = round.
      do_reset(2'd1, 2'd2, 2'd0);
      ready = 1'b1;
      pulse_start();
      chk("a2a_pkt0", {16'd0, data_o}, 153);
      @(negedge clk);
      chk("a2a_pkt1", {16'd0, data_o}, 152);
      repeat (15) @(negedge clk);
      chk("a2a_pkt16", {16'd0, data_o}, 409);
      repeat (48) @(negedge clk);
      chk("a2a_done", {31'd0, gen_done}, 1);
      chk("a2a_sent", sent, 64);
      chk("a2a_v_o", {31'd0, v_o}, 0);
      pulse_start();
      chk("a2a_restart_ignored", {31'd0, v_o}, 0);
      chk("a2a_done_held", {31'd0, gen_done}, 1);

      // Random mode from (0,0): LFSR 0x005A, 0x00B4, 0x0168 -> dest 10, 4, 8.
      do_reset(2'd0, 2'd0, 2'd2);
      ready = 1'b1;
      pulse_start();
      chk("rnd_pkt0", {16'd0, data_o}, 10);
      @(negedge clk);
      chk("rnd_pkt1", {16'd0, data_o}, 4);
      @(negedge clk);
      chk("rnd_pkt2", {16'd0, data_o}, 8);

      // Misroute into (0,0), then a good packet must not overwrite the code.
      do_reset(2'd0, 2'd0, 2'd0);
      v_inj = 1'b1; d_inj = 16'd15;
      #1;
      chk("yumi_comb", {31'd0, yumi}, 1);
      @(negedge clk);
      v_inj = 1'b0;
      chk("mis_err", {31'd0, err}, 1);
      chk("mis_code", {30'd0, code}, 1);
      chk("mis_recv", recv, 1);
      inject(16'd16);
      chk("mis_code_kept", {30'd0, code}, 1);
      chk("mis_recv2", recv, 2);

      // Sequence break from src (1,0): seq 0, 2, 3.
      do_reset(2'd0, 2'd0, 2'd0);
      inject(16'd16);
      chk("seq0_err", {31'd0, err}, 0);
      inject(16'd528);
      chk("seq2_err", {31'd0, err}, 1);
      chk("seq2_code", {30'd0, code}, 2);
      inject(16'd784);
      chk("seq3_code", {30'd0, code}, 2);
      chk("seq3_recv", recv, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
